// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder core:
// default code parameters, the encoder FSM state type and the parity helper.
package viterbi_pkg;

  localparam int         CONV_K      = 3;
  localparam int         CONV_M      = CONV_K - 1;
  localparam int         CONV_K_MAX  = 7;
  localparam logic [7:0] CONV_G0_OCT = 8'o07;
  localparam logic [7:0] CONV_G1_OCT = 8'o05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  // Parity of the taps selected by generator g; also used for decoder branch metrics.
  function automatic logic conv_parity(input logic [7:0] sr, input logic [7:0] g);
    return ^(sr & g);
  endfunction

endpackage

// File: rtl/conv_branch_sym.sv
// Combinational branch symbol: maps (state, input bit) to the 2-bit code symbol.
// Shared by the encoder datapath and the decoder's expected-symbol generation.
module conv_branch_sym
  import viterbi_pkg::*;
#(
  parameter int         K      = CONV_K,
  parameter logic [7:0] G0_OCT = CONV_G0_OCT,
  parameter logic [7:0] G1_OCT = CONV_G1_OCT
) (
  input  logic [K-2:0] i_sr_state,
  input  logic         i_b,
  output logic [1:0]   o_sym
);

  localparam logic [7:0] G_MASK = 8'((9'd1 << K) - 9'd1);
  localparam logic [7:0] G0_USE = G0_OCT & G_MASK;
  localparam logic [7:0] G1_USE = G1_OCT & G_MASK;

  logic [7:0] w_sr;

  // Newest bit sits in the LSB of the working register.
  assign w_sr  = 8'({i_sr_state, i_b});
  assign o_sym = {conv_parity(w_sr, G0_USE), conv_parity(w_sr, G1_USE)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 framed convolutional encoder with zero-tail termination and a single
// registered output stage. Define CONV_ENC_PUNCT_EN for rate-2/3 puncturing (adds tx_sym_mask).
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int         K      = CONV_K,
  parameter logic [7:0] G0_OCT = CONV_G0_OCT,
  parameter logic [7:0] G1_OCT = CONV_G1_OCT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit_valid,
  output logic       in_bit_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       tx_sym_valid,
  input  logic       tx_sym_ready,
  output logic [1:0] tx_sym,
`ifdef CONV_ENC_PUNCT_EN
  output logic [1:0] tx_sym_mask,
`endif
  output logic       busy
);

  localparam int M = K - 1;

  if (K < 3 || K > CONV_K_MAX) begin : g_bad_k
    $error("conv_encoder: K must be in 3..7");
  end
  if (!G0_OCT[K-1] || !G1_OCT[K-1]) begin : g_bad_gen
    $error("conv_encoder: generators must have bit K-1 set");
  end

  enc_state_t   r_fsm, w_fsm_nxt;
  logic [M-1:0] r_sr_state;
  logic [2:0]   r_tail_cnt, w_tail_cnt_nxt;
  logic         r_valid;
  logic [1:0]   r_sym;

  logic         w_adv, w_ready, w_acc, w_load, w_b;
  logic [K-1:0] w_sr;
  logic [1:0]   w_sym, w_sym_out;

  assign w_adv   = !r_valid || tx_sym_ready;
  assign w_ready = w_adv && (r_fsm != TAIL) && !rst;
  assign w_acc   = in_bit_valid && w_ready;
  assign w_load  = w_acc || ((r_fsm == TAIL) && w_adv);
  assign w_b     = (r_fsm == TAIL) ? 1'b0 : in_bit;
  assign w_sr    = {r_sr_state, w_b};

  conv_branch_sym #(
    .K      (K),
    .G0_OCT (G0_OCT),
    .G1_OCT (G1_OCT)
  ) u_branch_sym (
    .i_sr_state (r_sr_state),
    .i_b        (w_b),
    .o_sym      (w_sym)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_fsm_nxt      = r_fsm;
    w_tail_cnt_nxt = r_tail_cnt;
    case (r_fsm)
      IDLE, DATA: begin
        if (w_acc) begin
          if (in_last) begin
            w_fsm_nxt      = TAIL;
            w_tail_cnt_nxt = 3'(M);
          end else begin
            w_fsm_nxt = DATA;
          end
        end
      end
      TAIL: begin
        if (w_adv) begin
          w_tail_cnt_nxt = r_tail_cnt - 3'd1;
          if (r_tail_cnt == 3'd1) w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

`ifdef CONV_ENC_PUNCT_EN
  logic       r_phase;
  logic [1:0] r_mask;
  logic       w_phase;
  logic [1:0] w_mask;

  // A frame always starts on phase 0, whatever the previous frame ended on.
  assign w_phase     = (r_fsm == IDLE) ? 1'b0 : r_phase;
  assign w_mask      = w_phase ? 2'b10 : 2'b11;
  assign w_sym_out   = w_sym & w_mask;
  assign tx_sym_mask = r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b0;
      r_mask  <= 2'b00;
    end else if (w_load) begin
      r_phase <= !w_phase;
      r_mask  <= w_mask;
    end
  end
`else
  assign w_sym_out = w_sym;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= IDLE;
      r_sr_state <= '0;
      r_tail_cnt <= '0;
      r_valid    <= 1'b0;
      r_sym      <= 2'b00;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_tail_cnt <= w_tail_cnt_nxt;
      if (w_adv) r_valid <= w_load;
      if (w_load) begin
        r_sym      <= w_sym_out;
        r_sr_state <= w_sr[M-1:0];
      end
    end
  end

  assign in_bit_ready = w_ready;
  assign tx_sym_valid = r_valid;
  assign tx_sym       = r_sym;
  assign busy         = (r_fsm != IDLE);

endmodule
